// File: rtl/sseg_share_ctrl_pkg.sv
// Package: sseg_pkg
// Shared types for the 7-segment display sharing controller:
//   state_t  - controller FSM states
//   frame_t  - one display frame (8 hex digits, 8 decimal points, 8 digit enables)
//   FRAME_W  - width of frame_t in bits
//   max3()   - elaboration-time helper for sizing counters
package sseg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD
  } state_t;

  localparam int FRAME_W = 48;

  typedef struct packed {
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  LEs;
  } frame_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sseg_share_ctrl_rr_arbiter.sv
// Module: rr_arbiter
// Purely combinational round-robin pick. Scans req starting at ptr and wrapping
// modulo N; the first set bit wins. The pointer register lives in the parent.
// Ports:
//   req  in  N        request vector
//   ptr  in  IDX_W    index with highest priority this cycle (0..N-1)
//   gnt  out N        one-hot winner (all zero when no request)
//   idx  out IDX_W    index of winner (0 when no request)
//   any  out 1        at least one request present
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment infer latches.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_share_ctrl.sv
// Module: sseg_share_ctrl
// Shares one serial 7-segment display between NREQ requesters. A round-robin
// arbiter picks a requester in IDLE, its frame is latched and the display is
// started; the block then waits out the serializer shift and a minimum hold
// time. When idle for REFRESH_CYC cycles the current frame is re-sent.
// Ports:
//   clk         in   1         system clock
//   rstn        in   1         asynchronous active-low reset
//   req         in   NREQ      per-requester frame request (level)
//   req_hexs    in   NREQ*32   packed hex digits, requester i at [32*i+31:32*i]
//   req_points  in   NREQ*8    packed decimal points, requester i at [8*i+7:8*i]
//   req_LEs     in   NREQ*8    packed digit enables, requester i at [8*i+7:8*i]
//   ack         out  NREQ      one-hot 1-cycle pulse: frame captured
//   start       out  1         1-cycle pulse to display device
//   hexs        out  32        latched frame hex digits
//   points      out  8         latched decimal points
//   LEs         out  8         latched digit enables
//   owner       out  IDX_W     requester whose frame is shown
//   busy        out  1         high in LOAD/SHIFT/HOLD
module sseg_share_ctrl
  import sseg_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int SHIFT_CYCLES = 70,
  parameter int HOLD_CYCLES  = 1000,
  parameter int REFRESH_CYC  = 2**20,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_hexs,
  input  logic [NREQ*8-1:0]    req_points,
  input  logic [NREQ*8-1:0]    req_LEs,
  output logic [NREQ-1:0]      ack,
  output logic                 start,
  output logic [31:0]          hexs,
  output logic [7:0]           points,
  output logic [7:0]           LEs,
  output logic [IDX_W-1:0]     owner,
  output logic                 busy
);

  localparam int CNT_MAX_V = max3(SHIFT_CYCLES, HOLD_CYCLES, REFRESH_CYC);
  localparam int CNT_W     = $clog2(CNT_MAX_V + 1);

  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'((REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NREQ - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  frame_t           frame_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rr_ptr;
  logic             src_ack_q;

  logic [NREQ-1:0]    gnt;
  logic [IDX_W-1:0]   idx;
  logic               any;
  logic               take_grant;
  logic [FRAME_W-1:0] win_bits;
  frame_t             win_frame;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  // One-hot AND-OR mux of the winner's frame.
  always_comb begin
    win_bits = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_bits |= {req_hexs[32*i +: 32], req_points[8*i +: 8], req_LEs[8*i +: 8]};
      end
    end
  end

  assign win_frame = frame_t'(win_bits);
  assign next_ptr  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Next state and Moore outputs.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    start      = 1'b0;
    ack        = '0;
    busy       = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A request beats a refresh expiring in the same cycle.
        if (any) begin
          state_nxt  = S_LOAD;
          take_grant = 1'b1;
        end else if (REFRESH_CYC != 0 && cnt == REFRESH_LAST) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        start = 1'b1;
        busy  = 1'b1;
        if (src_ack_q) ack = NREQ'(1) << owner_q;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == SHIFT_LAST) state_nxt = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (cnt == HOLD_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the frame registers are reset because the display outputs must read
  // 0 during reset; a plain datapath register would normally be left unreset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      frame_q   <= '0;
      owner_q   <= '0;
      rr_ptr    <= '0;
      src_ack_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;
      // The counter restarts on every state entry and saturates otherwise.
      if (state_nxt != state) cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      if (state == S_IDLE && state_nxt == S_LOAD) src_ack_q <= take_grant;
      if (take_grant) begin
        frame_q <= win_frame;
        owner_q <= idx;
        rr_ptr  <= next_ptr;
      end
    end
  end

  assign hexs   = frame_q.hexs;
  assign points = frame_q.points;
  assign LEs    = frame_q.LEs;
  assign owner  = owner_q;

endmodule
